// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential double-dabble converter.
// Signed input mode is selected at build time with BCD_SIGNED_EN.
package bcd_pkg;

  localparam int DATA_W_DEF  = 20;
  localparam int DIGIT_W     = 4;
  localparam int NUM_DIGITS  = 6;
  localparam int BCD_W       = 24;
  localparam int CNT_W       = 5;
  localparam int BCD_MAX_DEF = 999999;

  localparam int DIG_UNIT  = 0;
  localparam int DIG_TEN   = 1;
  localparam int DIG_HUN   = 2;
  localparam int DIG_THO   = 3;
  localparam int DIG_T_THO = 4;
  localparam int DIG_H_HUN = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-nibble add-3 correction applied before each double-dabble shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_nib,
  output logic [DIGIT_W-1:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bcd_dabble_seq.sv
// One-shift-per-clock binary to six-digit BCD converter with sign/overflow.
// Define BCD_SIGNED_EN to treat bin as two's complement.
module bcd_dabble_seq
  import bcd_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIGITS  = NUM_DIGITS,
  parameter int BCD_MAX = BCD_MAX_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [3:0]        unit,
  output logic [3:0]        ten,
  output logic [3:0]        hun,
  output logic [3:0]        tho,
  output logic [3:0]        t_tho,
  output logic [3:0]        h_hun,
  output logic              sign,
  output logic              ovf
);

  localparam int BW = DIGITS * DIGIT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [BW-1:0] BCD_SAT = {DIGITS{4'h9}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_bin;
  logic [DATA_W-1:0] w_mag;
  logic [BW-1:0]     r_bcd;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_bcd_nxt;
  logic [BW-1:0]     r_dig;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign_c;
  logic              r_ovf_c;
  logic              w_sign_c;
  logic              w_ovf_c;
  logic              r_sign;
  logic              r_ovf;
  logic              r_done;
  logic              w_load;
  logic              w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_bcd[g*DIGIT_W +: DIGIT_W]),
      .o_nib (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_bcd_nxt = {w_adj[BW-2:0], r_bin[DATA_W-1]};

`ifdef BCD_SIGNED_EN
  // Negating the most negative value wraps to itself, which reads as
  // the correct unsigned magnitude.
  assign w_sign_c = bin[DATA_W-1];
  assign w_mag    = w_sign_c ? (~bin + DATA_W'(1)) : bin;
  assign w_ovf_c  = 1'b0;
`else
  assign w_sign_c = 1'b0;
  assign w_mag    = bin;
  assign w_ovf_c  = (bin > DATA_W'(BCD_MAX));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_sign_c <= 1'b0;
      r_ovf_c  <= 1'b0;
      r_dig    <= '0;
      r_sign   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_load) begin
        r_bin    <= w_mag;
        r_bcd    <= '0;
        r_cnt    <= '0;
        r_sign_c <= w_sign_c;
        r_ovf_c  <= w_ovf_c;
      end else if (r_state == SHIFT) begin
        r_bcd <= w_bcd_nxt;
        r_bin <= {r_bin[DATA_W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end
      // Digits only move on the final shift, never mid-conversion.
      if (w_last) begin
        r_dig  <= r_ovf_c ? BCD_SAT : w_bcd_nxt;
        r_ovf  <= r_ovf_c;
        r_sign <= r_sign_c & (|w_bcd_nxt);
      end
    end
  end

  assign busy  = (r_state == SHIFT);
  assign done  = r_done;
  assign sign  = r_sign;
  assign ovf   = r_ovf;
  assign unit  = r_dig[DIG_UNIT*DIGIT_W +: DIGIT_W];
  assign ten   = r_dig[DIG_TEN*DIGIT_W +: DIGIT_W];
  assign hun   = r_dig[DIG_HUN*DIGIT_W +: DIGIT_W];
  assign tho   = r_dig[DIG_THO*DIGIT_W +: DIGIT_W];
  assign t_tho = r_dig[DIG_T_THO*DIGIT_W +: DIGIT_W];
  assign h_hun = r_dig[DIG_H_HUN*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_bcd_dabble_seq.sv
// Scoreboard bench for bcd_dabble_seq: latency, digits, sign/ovf,
// start filtering while busy and mid-conversion reset.
module tb_bcd_dabble_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [19:0] bin;
  logic        busy;
  logic        done;
  logic [3:0]  unit, ten, hun, tho, t_tho, h_hun;
  logic        sign;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];
  logic [25:0] w_obs;

  assign w_obs = {h_hun, t_tho, tho, hun, ten, unit, sign, ovf};

  bcd_dabble_seq dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .unit    (unit),
    .ten     (ten),
    .hun     (hun),
    .tho     (tho),
    .t_tho   (t_tho),
    .h_hun   (h_hun),
    .sign    (sign),
    .ovf     (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [25:0] model(input logic [19:0] v);
    int m;
    logic s, o;
    logic [23:0] d;
    s = 1'b0;
    o = 1'b0;
    m = int'(v);
`ifdef BCD_SIGNED_EN
    if (v[19]) begin
      s = 1'b1;
      m = 1048576 - int'(v);
    end
`else
    if (m > 999999) begin
      o = 1'b1;
      m = 999999;
    end
`endif
    for (int i = 0; i < 6; i++) begin
      d[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    if (d == 24'h0) s = 1'b0;
    return {d, s, o};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start(input logic [19:0] v);
    bin   = v;
    start = 1'b1;
    exp_q.push_back(model(v));
    tick();
    start = 1'b0;
    bin   = 20'($urandom);
  endtask

  task automatic run_conv(output int lat, output int bad, output int chg);
    logic [25:0] snap;
    snap = w_obs;
    lat  = -1;
    bad  = 0;
    chg  = 0;
    if (busy !== 1'b1) bad++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) bad++;
      if (w_obs !== snap) chg++;
    end
  endtask

  always @(negedge sys_clk) begin
    if (done === 1'b1) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_busy: busy=%b with done, want 0", busy);
      end
    end
  end

  task automatic test_reset();
    sys_rst = 1'b1;
    start   = 1'b0;
    bin     = '0;
    repeat (3) tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctl: busy/done=%b want 00", {busy, done});
    end
    checks++;
    if (w_obs !== 26'h0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0", w_obs);
    end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat, bad, chg;
    logic [25:0] e;
    pulse_start(20'd0);
    run_conv(lat, bad, chg);
    checks++;
    if (lat !== 20) begin
      errors++;
      $display("FAIL zero_latency: got %0d want 20", lat);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL zero_busy: %0d cycles not busy, want 0", bad);
    end
    if (lat > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL zero_result: got %h want %h", w_obs, e);
      end
    end
  endtask

  task automatic test_values();
    logic [19:0] vals[8];
    int lat, bad, chg;
    logic [25:0] e;
    vals[0] = 20'd123456;
    vals[1] = 20'd999999;
    vals[2] = 20'd1048575;
    vals[3] = 20'd7;
    vals[4] = 20'd1000000;
    vals[5] = 20'($urandom_range(0, 999999));
    vals[6] = 20'($urandom_range(0, 1048575));
    vals[7] = 20'd5;
    for (int i = 0; i < 8; i++) begin
      pulse_start(vals[i]);
      run_conv(lat, bad, chg);
      checks++;
      if (lat !== 20 || bad !== 0) begin
        errors++;
        $display("FAIL val_timing[%0d]: lat=%0d bad=%0d want 20/0",
                 i, lat, bad);
      end
      checks++;
      if (chg !== 0) begin
        errors++;
        $display("FAIL val_hold[%0d]: digits moved %0d times, want 0",
                 i, chg);
      end
      if (lat > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (w_obs !== e) begin
          errors++;
          $display("FAIL val_result[%0d] bin=%0d: got %h want %h",
                   i, vals[i], w_obs, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad, chg, ndone;
    logic [25:0] e;
    ndone = 0;
    pulse_start(20'd314159);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k < 20 && done === 1'b1) ndone++;
      if (k == 4 || k == 11) begin
        start = 1'b1;
        bin   = 20'd271828;
      end
      if (k == 5 || k == 12) start = 1'b0;
    end
    checks++;
    if (ndone !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: early=%0d done=%b want 0/1", ndone, done);
    end
    if (done === 1'b1) begin
      e = exp_q.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL b2b_first: got %h want %h", w_obs, e);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    pulse_start(20'd86420);
    run_conv(lat, bad, chg);
    checks++;
    if (lat !== 20 || bad !== 0) begin
      errors++;
      $display("FAIL b2b_accept: lat=%0d bad=%0d want 20/0", lat, bad);
    end
    if (lat > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL b2b_second: got %h want %h", w_obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bad, chg, ndone;
    logic [25:0] e;
    ndone = 0;
    bin   = 20'd654321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    sys_rst = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b00 || w_obs !== 26'h0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b out=%h want 0/0/0",
               busy, done, w_obs);
    end
    sys_rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL rst_nodone: got %0d done pulses want 0", ndone);
    end
    pulse_start(20'd654321);
    run_conv(lat, bad, chg);
    checks++;
    if (lat !== 20) begin
      errors++;
      $display("FAIL rst_after_lat: got %0d want 20", lat);
    end
    if (lat > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL rst_after: got %h want %h", w_obs, e);
      end
    end
  endtask

  task automatic test_signed();
    logic [19:0] vals[3];
    int lat, bad, chg;
    logic [25:0] e;
    vals[0] = 20'hFFFFF;
    vals[1] = 20'h80000;
    vals[2] = 20'h7FFFF;
    for (int i = 0; i < 3; i++) begin
      pulse_start(vals[i]);
      run_conv(lat, bad, chg);
      checks++;
      if (lat !== 20) begin
        errors++;
        $display("FAIL sgn_lat[%0d]: got %0d want 20", i, lat);
      end
      if (lat > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (w_obs !== e) begin
          errors++;
          $display("FAIL sgn_result[%0d]: got %h want %h", i, w_obs, e);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard: %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_dabble_seq.md
Name: bcd_dabble_seq

Overview:
- Sequential shift-and-add-3 ("double dabble") binary-to-BCD converter.
- Sits directly upstream of the six-digit seven-segment scan driver.
- Takes a 20-bit value on a start pulse and produces six registered BCD digits (units..hundred-thousands) plus a sign flag.
- Uses one shift per clock, trading latency for area against the combinational converter.

Parameters:
- DATA_W, 20, binary input width; the design is verified only at 20.
- DIGITS, 6, number of BCD output digits; the design is verified only at 6.
- BCD_MAX, 999999, saturation value for unsigned overflow.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  conversion request, sampled only in IDLE.
- bin  in  DATA_W  binary value, sampled on the accepted start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; digits valid from this cycle.
- unit  out  4  BCD digit 0.
- ten  out  4  BCD digit 1.
- hun  out  4  BCD digit 2.
- tho  out  4  BCD digit 3.
- t_tho  out  4  BCD digit 4.
- h_hun  out  4  BCD digit 5.
- sign  out  1  1 = negative result.
- ovf  out  1  1 = input exceeded BCD_MAX and result saturated.

Behaviour:
- Clocking and reset: one clock (sys_clk); reset is synchronous and active-high (sys_rst).
- Reset values: busy=0, done=0, sign=0, ovf=0, all digits 0, state IDLE, internal shift/BCD regs 0.
- Reset asserted mid-conversion aborts immediately to the reset state; there is no partial result and no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On start=1 at edge N: load magnitude of bin into the binary shift reg.
  - Clear the 24-bit BCD accumulator and shift counter (5 bits).
  - Latch sign and overflow candidates; go to SHIFT.
  - busy=1 from edge N.
- SHIFT, each edge:
  - Add 3 to every BCD nibble >= 5.
  - Shift {bcd, bin_reg} left by one.
  - Increment the counter.
- When the counter is 19 (the 20th shift, edge N+20):
  - Write the corrected, shifted result to the digit outputs.
  - Update sign/ovf; done=1 for exactly that cycle; busy=0; return to IDLE.
- Latency: start at edge N -> done and digits at edge N+20. Throughput is one conversion per 21 cycles, because start is accepted again in the cycle done is high.
- Start while busy is ignored; it is neither queued nor restarting.
- bin changing during a conversion has no effect.
- Digit outputs hold their last result until the next done; they never show intermediate values.
- Unsigned overflow: if the loaded value > BCD_MAX (1000000..1048575), outputs = 9,9,9,9,9,9 and ovf=1. Otherwise ovf=0.
- done is never asserted with busy=1.

Optional Feature:
- Macro: BCD_SIGNED_EN.
- Defined:
  - bin is interpreted as DATA_W-bit two's complement.
  - At load, sign <= bin[DATA_W-1] and magnitude <= |bin|; -524288 converts to 524288.
  - ovf is always 0.
  - A zero result forces sign=0.
- Undefined:
  - bin is unsigned; sign is tied 0.
  - Overflow saturation applies as above.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4, NUM_DIGITS=6, BCD_W=24, CNT_W=5, BCD_MAX constant.
  - State enum type (IDLE, SHIFT).
  - Digit-index constants.
- Sub-module bcd_add3: combinational 4-bit nibble correction (in >= 5 ? in+3 : in), instantiated DIGITS times.

Test Plan:
- bin=0, start pulse: done exactly 20 cycles later, all digits 0, ovf=0, busy high for cycles 0..19.
- bin=123456: digits h_hun..unit = 1,2,3,4,5,6; then bin=999999: all 9, ovf=0.
- bin=1048575 (unsigned build): all digits 9, ovf=1; then bin=7 clears ovf and gives unit=7, the rest 0.
- start re-pulsed at cycle 5 and cycle 12 of a conversion: single done at cycle 20 with the first value; start in the done cycle is accepted.
- sys_rst asserted at cycle 10 of converting 654321: next cycle busy=0, digits 0, no done; a following conversion is correct.
- BCD_SIGNED_EN defined, bin=20'hFFFFF: sign=1, digits 000001. bin=20'h80000: sign=1, digits 524288.
